// File: rtl/riscv_definitions.sv
// Shared definitions for the unified memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : result of the IDLE-cycle grant decision
//   NOP_INSTR   : word returned to the fetch port when a transaction is aborted
package riscv_definitions;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arb_fairness.sv
// Grant decision and data-streak counter for the unified memory arbiter.
// Only meaningful in IDLE cycles (arb_en high).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   arb_en       : arbiter is in IDLE and may grant this cycle
//   data_req     : data port requesting
//   fetch_req    : fetch port requesting
//   grant        : which port wins (valid with grant_valid)
//   grant_valid  : a grant is issued this cycle
module arb_fairness
  import riscv_definitions::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_en,
  input  logic       data_req,
  input  logic       fetch_req,
  output arb_grant_t grant,
  output logic       grant_valid
);

  logic [3:0] streak;

  always_comb begin
    grant_valid = arb_en & (data_req | fetch_req);
    // Data wins unless a waiting fetch has already been passed over
    // MAX_D_STREAK times in a row.
    if (data_req && !(fetch_req && (streak == 4'(MAX_D_STREAK))))
      grant = GRANT_D;
    else
      grant = GRANT_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= 4'd0;
    end else if (grant_valid) begin
      if (grant == GRANT_I)
        streak <= 4'd0;
      else if (fetch_req)
        streak <= streak + 4'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction
// fetch port and the data port. Level-held core requests become one memory
// transaction at a time; completion is a one-cycle ready pulse with data.
// Optional feature macro: ARB_TIMEOUT_EN (adds o_bus_err and a wait timeout).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   i_inst_*  / o_instr_*      : fetch request (byte enables) and response
//   i_data_*  / o_data_*       : load/store request and response
//   o_mem_* / i_mem_*          : memory side, req held until one-cycle ack
//   o_bus_err (ARB_TIMEOUT_EN) : sticky, set when a transaction times out
//
// state | meaning
// IDLE  | arbitrate between ports, capture winning request
// BUS_I | fetch transaction on memory, waiting for ack
// BUS_D | data transaction on memory, waiting for ack
// RESP  | ready pulse to the served port, requests ignored
module unified_mem_arbiter
  import riscv_definitions::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_inst_addr,
  input  logic [3:0]            i_inst_rd_en,
  output logic                  o_instr_ready,
  output logic [DATA_WIDTH-1:0] o_instr_data,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wr,
  input  logic [3:0]            i_data_rd_en_ctrl,
  input  logic                  i_data_rd_en,
  input  logic                  i_data_wr_en,
  output logic                  o_data_ready,
  output logic [DATA_WIDTH-1:0] o_data_rd,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ack,
`ifdef ARB_TIMEOUT_EN
  output logic                  o_bus_err,
`endif
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_t state;
  arb_grant_t grant;
  logic       grant_valid;
  logic       data_req;
  logic       fetch_req;

  assign data_req  = i_data_rd_en | i_data_wr_en;
  assign fetch_req = |i_inst_rd_en;

  arb_fairness #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_fairness (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (state == IDLE),
    .data_req    (data_req),
    .fetch_req   (fetch_req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter: loaded on grant, abort when it reaches zero without ack.
  logic [TW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      o_instr_ready <= 1'b0;
      o_instr_data  <= '0;
      o_data_ready  <= 1'b0;
      o_data_rd     <= '0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_be      <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      o_bus_err     <= 1'b0;
`endif
    end else begin
      o_instr_ready <= 1'b0;
      o_data_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            o_mem_req <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            wait_cnt  <= TW'(TIMEOUT_CYCLES - 1);
`endif
            if (grant == GRANT_D) begin
              o_mem_addr  <= i_data_addr;
              o_mem_wdata <= i_data_wr;
              o_mem_be    <= i_data_rd_en_ctrl;
              // A simultaneous load+store request is performed as a store.
              o_mem_we    <= i_data_wr_en;
              state       <= BUS_D;
            end else begin
              o_mem_addr  <= i_inst_addr;
              o_mem_wdata <= '0;
              o_mem_be    <= i_inst_rd_en;
              o_mem_we    <= 1'b0;
              state       <= BUS_I;
            end
          end
        end
        BUS_I, BUS_D: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state     <= RESP;
            if (state == BUS_I) begin
              o_instr_ready <= 1'b1;
              o_instr_data  <= i_mem_rdata;
            end else begin
              o_data_ready <= 1'b1;
              o_data_rd    <= o_mem_we ? '0 : i_mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == '0) begin
            o_mem_req <= 1'b0;
            o_bus_err <= 1'b1;
            state     <= RESP;
            if (state == BUS_I) begin
              o_instr_ready <= 1'b1;
              o_instr_data  <= DATA_WIDTH'(NOP_INSTR);
            end else begin
              o_data_ready <= 1'b1;
              o_data_rd    <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: table-driven single
// transactions, directed corner sequences and a randomized run against a
// transaction-level timeline model.
module tb_unified_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_inst_addr;
  logic [3:0]  i_inst_rd_en;
  logic        o_instr_ready;
  logic [31:0] o_instr_data;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wr;
  logic [3:0]  i_data_rd_en_ctrl;
  logic        i_data_rd_en;
  logic        i_data_wr_en;
  logic        o_data_ready;
  logic [31:0] o_data_rd;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
`ifdef ARB_TIMEOUT_EN
  logic        o_bus_err;
`endif

  unified_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_inst_addr(i_inst_addr), .i_inst_rd_en(i_inst_rd_en),
    .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
    .i_data_addr(i_data_addr), .i_data_wr(i_data_wr),
    .i_data_rd_en_ctrl(i_data_rd_en_ctrl), .i_data_rd_en(i_data_rd_en),
    .i_data_wr_en(i_data_wr_en), .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
`ifdef ARB_TIMEOUT_EN
    .o_bus_err(o_bus_err),
`endif
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory responder
  bit          mem_en = 1'b0;
  bit          mem_active = 1'b0;
  int          mem_left = 0;
  int          forced_wait = 0;
  logic [31:0] next_rdata = '0;
  bit          force_ack = 1'b0;

  // random core and reference model
  bit          rnd_mode = 1'b0;
  bit          i_pend, d_pend;
  bit          m_busy, m_ack_seen, m_port, m_we;
  int          m_grant_cyc, m_ack_cyc, m_rdy_cyc, m_next_arb, m_streak;
  logic [31:0] m_addr, m_wdata, m_rdy_data;
  logic [3:0]  m_be;

  typedef struct {
    bit          is_data;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_st;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_inst_addr = '0; i_inst_rd_en = '0;
    i_data_addr = '0; i_data_wr = '0; i_data_rd_en_ctrl = '0;
    i_data_rd_en = 1'b0; i_data_wr_en = 1'b0;
  endtask

  task automatic mem_drive();
    i_mem_ack = force_ack;
    force_ack = 1'b0;
    if (mem_en && o_mem_req && !mem_active) begin
      mem_active = 1'b1;
      mem_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 4));
    end
    if (mem_active) begin
      if (mem_left == 0) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = rnd_mode ? 32'($urandom) : next_rdata;
        mem_active  = 1'b0;
      end else begin
        mem_left--;
      end
    end
  endtask

  task automatic core_drive();
    int kind;
    if (o_instr_ready) i_pend = 1'b0;
    if (o_data_ready)  d_pend = 1'b0;
    if (!i_pend) begin
      if ($urandom_range(0, 2) == 0) begin
        i_inst_addr  = 32'($urandom) & 32'hFFFF_FFFC;
        i_inst_rd_en = 4'($urandom_range(1, 15));
        i_pend = 1'b1;
      end else i_inst_rd_en = 4'd0;
    end
    if (!d_pend) begin
      if ($urandom_range(0, 1) == 0) begin
        kind = int'($urandom_range(0, 2));
        i_data_addr       = 32'($urandom);
        i_data_wr         = 32'($urandom);
        i_data_rd_en_ctrl = 4'($urandom_range(1, 15));
        i_data_rd_en      = (kind != 1);
        i_data_wr_en      = (kind != 0);
        d_pend = 1'b1;
      end else begin
        i_data_rd_en = 1'b0; i_data_wr_en = 1'b0;
      end
    end
  endtask

  // Timeline model: a grant in cycle g puts the request on the bus from g+1
  // through the ack cycle a, ready appears in a+1, next arbitration at a+2.
  task automatic model_check();
    bit exp_req, dreq, freq;
    exp_req = m_busy && (cyc > m_grant_cyc) && !(m_ack_seen && cyc > m_ack_cyc);
    chk("rnd_mem_req", 32'(o_mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("rnd_mem_addr", o_mem_addr, m_addr);
      chk("rnd_mem_we", 32'(o_mem_we), 32'(m_we));
      chk("rnd_mem_be", 32'(o_mem_be), 32'(m_be));
      if (m_we) chk("rnd_mem_wdata", o_mem_wdata, m_wdata);
      if (i_mem_ack && !m_ack_seen) begin
        m_ack_seen = 1'b1;
        m_ack_cyc  = cyc;
        m_rdy_cyc  = cyc + 1;
        m_rdy_data = m_we ? 32'd0 : i_mem_rdata;
      end
    end
    chk("rnd_instr_ready", 32'(o_instr_ready),
        32'(m_busy && m_ack_seen && cyc == m_rdy_cyc && !m_port));
    chk("rnd_data_ready", 32'(o_data_ready),
        32'(m_busy && m_ack_seen && cyc == m_rdy_cyc && m_port));
    if (m_busy && m_ack_seen && cyc == m_rdy_cyc) begin
      if (m_port) chk("rnd_data_rd", o_data_rd, m_rdy_data);
      else        chk("rnd_instr_data", o_instr_data, m_rdy_data);
      m_busy = 1'b0;
      m_next_arb = cyc + 1;
    end
    if (!m_busy && cyc >= m_next_arb) begin
      dreq = i_data_rd_en | i_data_wr_en;
      freq = (i_inst_rd_en != 4'd0);
      if (dreq || freq) begin
        m_port = dreq && !(freq && m_streak == MAXS);
        if (!m_port) m_streak = 0;
        else if (freq) m_streak++;
        if (m_port) begin
          m_addr = i_data_addr; m_we = i_data_wr_en;
          m_be = i_data_rd_en_ctrl; m_wdata = i_data_wr;
        end else begin
          m_addr = i_inst_addr; m_we = 1'b0; m_be = i_inst_rd_en; m_wdata = '0;
        end
        m_busy = 1'b1; m_ack_seen = 1'b0; m_grant_cyc = cyc;
      end
    end
  endtask

  // One clock: inputs change #1 after the rising edge, checks on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    mem_drive();
    if (rnd_mode) core_drive();
    @(negedge clk);
    if (rnd_mode) model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    mem_active = 1'b0;
    force_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k0, nreq, first_req;
    bit done;
    forced_wait = v.wait_st; next_rdata = v.rdata; mem_en = 1'b1;
    if (v.is_data) begin
      i_data_addr = v.addr; i_data_wr = v.wdata; i_data_rd_en_ctrl = v.be;
      i_data_rd_en = v.rd; i_data_wr_en = v.wr;
    end else begin
      i_inst_addr = v.addr; i_inst_rd_en = v.be;
    end
    k0 = cyc; nreq = 0; first_req = -1; done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      tick();
      if (o_mem_req) begin
        nreq++;
        if (first_req < 0) first_req = cyc;
        chk($sformatf("vec%0d_addr", idx), o_mem_addr, v.addr);
        chk($sformatf("vec%0d_we", idx), 32'(o_mem_we), 32'(v.exp_we));
        chk($sformatf("vec%0d_be", idx), 32'(o_mem_be), 32'(v.be));
        if (v.exp_we) chk($sformatf("vec%0d_wdata", idx), o_mem_wdata, v.wdata);
      end
      if (o_instr_ready || o_data_ready) begin
        done = 1'b1;
        chk($sformatf("vec%0d_latency", idx), 32'(cyc - k0), 32'(v.exp_lat));
        chk($sformatf("vec%0d_port", idx), 32'(o_data_ready), 32'(v.is_data));
        chk($sformatf("vec%0d_both_ready", idx), 32'(o_data_ready & o_instr_ready), 32'd0);
        chk($sformatf("vec%0d_data", idx), v.is_data ? o_data_rd : o_instr_data, v.exp_data);
        chk($sformatf("vec%0d_req_cycles", idx), 32'(nreq), 32'(v.wait_st + 1));
        chk($sformatf("vec%0d_req_start", idx), 32'(first_req - k0), 32'd1);
        clear_inputs();
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL vec%0d_timeout: no ready within 30 cycles", idx);
      clear_inputs();
    end
    repeat (3) begin
      tick();
      chk($sformatf("vec%0d_no_regrant", idx), 32'(o_mem_req), 32'd0);
      chk($sformatf("vec%0d_no_ready", idx), 32'(o_instr_ready | o_data_ready), 32'd0);
    end
  endtask

  initial begin
    int k0, ng, d_rdy, i_rdy;
    int got[10];
    bit done;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h100,  32'h0,        4'hF, 0, 32'h0050_0093, 1'b0, 32'h0050_0093, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h2000, 32'h0,        4'hF, 5, 32'h1234_5678, 1'b0, 32'h1234_5678, 7};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 0, 32'hAAAA_5555, 1'b1, 32'h0,         2};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h44,   32'h0102_0304, 4'hC, 2, 32'hFFFF_FFFF, 1'b1, 32'h0,         4};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h104,  32'h0,        4'h3, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3};

    i_mem_ack = 1'b0; i_mem_rdata = '0;
    do_reset();
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(o_mem_be), 32'd0);
    chk("rst_readies", 32'({o_instr_ready, o_data_ready}), 32'd0);
    chk("rst_instr_data", o_instr_data, 32'd0);
    chk("rst_data_rd", o_data_rd, 32'd0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i], i);

    // store and fetch requested together: store first, then fetch, no overlap
    do_reset();
    mem_en = 1'b1; forced_wait = 0; next_rdata = 32'h0000_1111;
    i_data_addr = 32'h2000; i_data_wr = 32'hDEAD_BEEF; i_data_rd_en_ctrl = 4'h3;
    i_data_wr_en = 1'b1;
    i_inst_addr = 32'h200; i_inst_rd_en = 4'hF;
    k0 = cyc; d_rdy = -1; i_rdy = -1;
    for (int n = 0; n < 30 && i_rdy < 0; n++) begin
      tick();
      if (cyc == k0 + 1) begin
        chk("sf_first_we", 32'(o_mem_we), 32'd1);
        chk("sf_first_be", 32'(o_mem_be), 32'h3);
        chk("sf_first_addr", o_mem_addr, 32'h2000);
      end
      chk("sf_ready_overlap", 32'(o_instr_ready & o_data_ready), 32'd0);
      if (o_data_ready) begin d_rdy = cyc - k0; i_data_wr_en = 1'b0; end
      if (o_instr_ready) begin
        i_rdy = cyc - k0; i_inst_rd_en = 4'd0;
        chk("sf_instr_data", o_instr_data, 32'h0000_1111);
      end
    end
    chk("sf_data_ready_cycle", 32'(d_rdy), 32'd2);
    chk("sf_instr_ready_cycle", 32'(i_rdy), 32'd5);
    clear_inputs();

    // data held continuously with a fetch pending: D,D,D,D,I repeating
    do_reset();
    mem_en = 1'b1; forced_wait = 0; next_rdata = 32'h5A5A_0000;
    i_data_addr = 32'h400; i_data_rd_en_ctrl = 4'hF; i_data_rd_en = 1'b1;
    i_inst_addr = 32'h500; i_inst_rd_en = 4'hF;
    ng = 0;
    for (int n = 0; n < 100 && ng < 10; n++) begin
      tick();
      if (o_data_ready) begin got[ng] = 1; ng++; end
      else if (o_instr_ready) begin got[ng] = 0; ng++; end
    end
    chk("streak_grant_count", 32'(ng), 32'd10);
    for (int i = 0; i < ng; i++)
      chk($sformatf("streak_grant%0d", i), 32'(got[i]), (i % 5 == 4) ? 32'd0 : 32'd1);
    clear_inputs();
    repeat (3) tick();

    // reset during BUS_D, then a late ack must be ignored
    do_reset();
    mem_en = 1'b0;
    i_data_addr = 32'h80; i_data_rd_en_ctrl = 4'hF; i_data_rd_en = 1'b1;
    tick();
    tick();
    chk("rstmid_req_before", 32'(o_mem_req), 32'd1);
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req", 32'(o_mem_req), 32'd0);
    chk("rstmid_addr", o_mem_addr, 32'd0);
    chk("rstmid_be", 32'(o_mem_be), 32'd0);
    chk("rstmid_readies", 32'({o_instr_ready, o_data_ready}), 32'd0);
    rst_n = 1'b1;
    force_ack = 1'b1; next_rdata = 32'hBAD0_BAD0;
    repeat (4) begin
      tick();
      chk("rstmid_late_req", 32'(o_mem_req), 32'd0);
      chk("rstmid_late_ready", 32'({o_instr_ready, o_data_ready}), 32'd0);
      chk("rstmid_data_rd", o_data_rd, 32'd0);
    end

    // randomized traffic against the timeline model
    do_reset();
    mem_en = 1'b1; forced_wait = -1;
    i_pend = 1'b0; d_pend = 1'b0;
    m_busy = 1'b0; m_ack_seen = 1'b0; m_next_arb = 0; m_streak = 0;
    m_grant_cyc = 0; m_ack_cyc = 0; m_rdy_cyc = 0;
    rnd_mode = 1'b1;
    repeat (2000) tick();
    rnd_mode = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // fetch with no ack: aborted after TO bus cycles
    do_reset();
    mem_en = 1'b0;
    i_inst_addr = 32'h300; i_inst_rd_en = 4'hF;
    k0 = cyc; ng = 0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (o_mem_req) ng++;
      if (o_instr_ready) begin
        done = 1'b1;
        i_inst_rd_en = 4'd0;
        chk("to_latency", 32'(cyc - k0), 32'(TO + 1));
        chk("to_instr_data", o_instr_data, 32'h0000_0013);
        chk("to_bus_err", 32'(o_bus_err), 32'd1);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL to_no_ready: no abort within 40 cycles");
    end
    chk("to_req_cycles", 32'(ng), 32'(TO));
    clear_inputs();
    repeat (5) tick();
    chk("to_bus_err_sticky", 32'(o_bus_err), 32'd1);
    chk("to_req_idle", 32'(o_mem_req), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
